// File: rtl/add_acc_pipe_pkg.sv
// add_acc_pipe_pkg: shared mode and state enums for the registered adder/accumulator family.
package add_pkg;
  typedef enum logic {ADD_MODE_SUM, ADD_MODE_ACC} add_mode_e;
  typedef enum logic {ADD_EMPTY, ADD_FULL} add_state_e;
endpackage

// File: rtl/add_acc_pipe_if.sv
// add_acc_pipe_if: operand, handshake and result bundle between a producer and add_acc_pipe.
interface add_acc_if import add_pkg::*; #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  add_mode_e        mode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y;
  logic             ovf;
  logic [CNT_W-1:0] count;
  modport master (output in_valid, a, b, mode, acc_clr, out_ready,
                  input  in_ready, out_valid, y, ovf, count);
  modport slave  (input  in_valid, a, b, mode, acc_clr, out_ready,
                  output in_ready, out_valid, y, ovf, count);
endinterface

// File: rtl/add_acc_pipe_core.sv
// add_core: combinational SUM/ACC datapath; a same-cycle clear zeroes the accumulator before adding.
module add_core import add_pkg::*; #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH:0]   i_acc,
  input  add_mode_e        i_mode,
  input  logic             i_clr,
  input  logic             i_sat,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);
  logic [WIDTH:0]   w_base;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH:0]   w_add;
  logic             w_acc_ovf;
  assign w_base    = i_clr ? '0 : i_acc;
  assign w_sum     = {1'b0, w_base} + (WIDTH+2)'(i_a);
  assign w_add     = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b);
  assign w_acc_ovf = w_sum[WIDTH+1];
  assign o_ovf     = (i_mode == ADD_MODE_ACC) & w_acc_ovf;
  assign o_result  = (i_mode == ADD_MODE_SUM) ? w_add :
                     (w_acc_ovf & i_sat)      ? '1    : w_sum[WIDTH:0];
endmodule

// File: rtl/add_acc_pipe.sv
// add_acc_pipe: one-deep registered adder/accumulator behind valid/ready with a transaction counter.
// Define ADD_ACC_SAT_EN to saturate ACC overflow to all-ones instead of wrapping.
module add_acc_pipe import add_pkg::*; #(parameter int WIDTH = 4, parameter int CNT_W = 8) (
  input  logic  clk,
  input  logic  rst_n,
  add_acc_if.slave bus
);
  add_state_e       r_state;
  logic [WIDTH:0]   r_y;
  logic [WIDTH:0]   r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_sat;
  logic [WIDTH:0]   w_result;
  logic             w_ovf;
`ifdef ADD_ACC_SAT_EN
  assign w_sat = 1'b1;
`else
  assign w_sat = 1'b0;
`endif
  assign bus.out_valid = (r_state == ADD_FULL);
  assign bus.in_ready  = !bus.out_valid | bus.out_ready;
  assign bus.y         = r_y;
  assign bus.ovf       = r_ovf;
  assign bus.count     = r_count;
  assign w_accept      = bus.in_valid & bus.in_ready;
  add_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_acc    (r_acc),
    .i_mode   (bus.mode),
    .i_clr    (bus.acc_clr),
    .i_sat    (w_sat),
    .o_result (w_result),
    .o_ovf    (w_ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ADD_EMPTY;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_accept ? ADD_FULL : (bus.out_ready ? ADD_EMPTY : r_state);
      if (w_accept) begin
        r_y     <= w_result;
        r_ovf   <= w_ovf;
        r_count <= (bus.acc_clr ? '0 : r_count) + CNT_W'(1);
        if (bus.mode == ADD_MODE_ACC) r_acc <= w_result;
        else if (bus.acc_clr)         r_acc <= '0;
      end else if (bus.acc_clr) begin
        r_acc   <= '0;
        r_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_add_acc_pipe.sv
// tb_add_acc_pipe: directed vectors with hand-computed results for add_acc_pipe (WIDTH=4).
module tb_add_acc_pipe;
  import add_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  add_acc_if #(.WIDTH(4), .CNT_W(8)) bus ();
  add_acc_pipe #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input add_mode_e m, input logic [3:0] a, input logic [3:0] b, input logic clr);
    bus.in_valid = v;
    bus.mode     = m;
    bus.a        = a;
    bus.b        = b;
    bus.acc_clr  = clr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [4:0] y, input logic o, input logic [7:0] c);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".y"},     32'(bus.y),         32'(y));
    check({tag, ".ovf"},   32'(bus.ovf),       32'(o));
    check({tag, ".count"}, 32'(bus.count),     32'(c));
  endtask
  initial begin
    drive(1'b0, ADD_MODE_SUM, 4'd0, 4'd0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    expect_out("reset", 1'b0, 5'd0, 1'b0, 8'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    drive(1'b1, ADD_MODE_SUM, 4'd3, 4'd4, 1'b0);
    tick();
    expect_out("sum3p4", 1'b1, 5'd7, 1'b0, 8'd1);
    drive(1'b1, ADD_MODE_SUM, 4'd15, 4'd15, 1'b0);
    tick();
    expect_out("sum15p15", 1'b1, 5'd30, 1'b0, 8'd2);
    drive(1'b0, ADD_MODE_SUM, 4'd0, 4'd0, 1'b0);
    tick();
    check("drain.valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, ADD_MODE_SUM, 4'd3, 4'd4, 1'b0);
    tick();
    expect_out("stall1", 1'b1, 5'd7, 1'b0, 8'd3);
    check("stall1.in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, ADD_MODE_SUM, 4'd5, 4'd7, 1'b0);
    tick();
    expect_out("stall2", 1'b1, 5'd7, 1'b0, 8'd3);
    tick();
    expect_out("stall3", 1'b1, 5'd7, 1'b0, 8'd3);
    bus.out_ready = 1'b1;
    #1;
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    expect_out("released", 1'b1, 5'd12, 1'b0, 8'd4);
    drive(1'b0, ADD_MODE_SUM, 4'd0, 4'd0, 1'b1);
    tick();
    check("clr.count", 32'(bus.count), 32'd0);
    check("clr.valid", 32'(bus.out_valid), 32'd0);
    check("clr.y", 32'(bus.y), 32'd12);
    drive(1'b1, ADD_MODE_ACC, 4'd15, 4'd9, 1'b0);
    tick();
    expect_out("acc1", 1'b1, 5'd15, 1'b0, 8'd1);
    tick();
    expect_out("acc2", 1'b1, 5'd30, 1'b0, 8'd2);
    tick();
`ifdef ADD_ACC_SAT_EN
    expect_out("acc3", 1'b1, 5'd31, 1'b1, 8'd3);
    drive(1'b1, ADD_MODE_ACC, 4'd1, 4'd0, 1'b0);
    tick();
    expect_out("acc4", 1'b1, 5'd31, 1'b1, 8'd4);
`else
    expect_out("acc3", 1'b1, 5'd13, 1'b1, 8'd3);
    drive(1'b1, ADD_MODE_ACC, 4'd1, 4'd0, 1'b0);
    tick();
    expect_out("acc4", 1'b1, 5'd14, 1'b0, 8'd4);
`endif
    drive(1'b1, ADD_MODE_ACC, 4'd7, 4'd0, 1'b1);
    tick();
    expect_out("clracc7", 1'b1, 5'd7, 1'b0, 8'd1);
    drive(1'b1, ADD_MODE_ACC, 4'd3, 4'd0, 1'b0);
    tick();
    expect_out("acc10", 1'b1, 5'd10, 1'b0, 8'd2);
    drive(1'b1, ADD_MODE_ACC, 4'd5, 4'd0, 1'b1);
    tick();
    expect_out("clracc5", 1'b1, 5'd5, 1'b0, 8'd1);
    drive(1'b1, ADD_MODE_ACC, 4'd1, 4'd0, 1'b0);
    tick();
    expect_out("acc6", 1'b1, 5'd6, 1'b0, 8'd2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ADD_MODE_SUM, 4'(i), 4'(i + 1), 1'b0);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, 5'(2 * i + 1), 1'b0, 8'(3 + i));
    end
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 5'd0, 1'b0, 8'd0);
    check("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    expect_out("held_rst", 1'b0, 5'd0, 1'b0, 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
